// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - ordered write-back queue in front of the register bank write port
// Optional forwarding logic is built only when WBQ_FORWARD_EN is defined.
module reg_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_reg,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     hold,
    output logic [ADDR_W-1:0]        writeReg,
    output logic [DATA_W-1:0]        writeData,
    output logic                     regWrite,
    input  logic [ADDR_W-1:0]        qReg1,
    input  logic [ADDR_W-1:0]        qReg2,
    output logic                     qHit1,
    output logic                     qHit2,
    output logic [DATA_W-1:0]        qData1,
    output logic [DATA_W-1:0]        qData2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] reg_q  [DEPTH];
    logic [ADDR_W-1:0] reg_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic accept;
    logic enq;
    logic retire;

    assign in_ready  = (count_q < FULL_CNT);
    assign regWrite  = (count_q != '0) && !hold;
    assign writeReg  = reg_q[head_q];
    assign writeData = data_q[head_q];
    assign count     = count_q;

    // Register 0 writes complete the handshake but are never stored.
    assign accept = in_valid && in_ready;
    assign enq    = accept && (in_reg != '0);
    assign retire = regWrite;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        reg_d   = reg_q;
        data_d  = data_q;
        if (enq) begin
            reg_d[tail_q]  = in_reg;
            data_d[tail_q] = in_data;
            tail_d         = tail_q + PTR_W'(1);
        end
        if (retire) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({enq, retire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
        end
    end

`ifdef WBQ_FORWARD_EN
    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        qHit1  = 1'b0;
        qHit2  = 1'b0;
        qData1 = '0;
        qData2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
                if ((qReg1 != '0) && (reg_q[head_q + PTR_W'(i)] == qReg1)) begin
                    qHit1  = 1'b1;
                    qData1 = data_q[head_q + PTR_W'(i)];
                end
                if ((qReg2 != '0) && (reg_q[head_q + PTR_W'(i)] == qReg2)) begin
                    qHit2  = 1'b1;
                    qData2 = data_q[head_q + PTR_W'(i)];
                end
            end
        end
    end
`else
    logic unused_qreg;
    assign unused_qreg = ^{qReg1, qReg2};
    assign qHit1  = 1'b0;
    assign qHit2  = 1'b0;
    assign qData1 = '0;
    assign qData2 = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb/tb_reg_writeback_queue.sv - directed self-checking bench for reg_writeback_queue
module tb_reg_writeback_queue;

`ifdef WBQ_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_reg;
    logic [31:0] in_data;
    logic        hold;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        regWrite;
    logic [4:0]  qReg1, qReg2;
    logic        qHit1, qHit2;
    logic [31:0] qData1, qData2;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    reg_writeback_queue #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .hold(hold), .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
        .qReg1(qReg1), .qReg2(qReg2), .qHit1(qHit1), .qHit2(qHit2),
        .qData1(qData1), .qData2(qData2), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        in_valid = 1'b1;
        in_reg   = r;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0;
        hold = 1'b0; qReg1 = '0; qReg2 = '0;
        step(); step();
        rst_n = 1'b0;
        #3;
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_regWrite", 64'(regWrite), 64'd0);
        check("rst_writeReg", 64'(writeReg), 64'd0);
        check("rst_writeData", 64'(writeData), 64'd0);
        check("rst_qHit1", 64'(qHit1), 64'd0);
        check("rst_qData1", 64'(qData1), 64'd0);

        // Single write: 1-cycle accept-to-commit
        push(5'd5, 32'hDEADBEEF);
        check("single_regWrite", 64'(regWrite), 64'd1);
        check("single_writeReg", 64'(writeReg), 64'd5);
        check("single_writeData", 64'(writeData), 64'hDEADBEEF);
        check("single_count1", 64'(count), 64'd1);
        step();
        check("single_count0", 64'(count), 64'd0);
        check("single_idle", 64'(regWrite), 64'd0);

        // Fill while held
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'(17 * i));
        check("fill_count", 64'(count), 64'd4);
        check("fill_in_ready", 64'(in_ready), 64'd0);
        check("fill_held", 64'(regWrite), 64'd0);
        qReg1 = 5'd3;
        #1;
        check("fill_qHit1", 64'(qHit1), FWD ? 64'd1 : 64'd0);
        check("fill_qData1", 64'(qData1), FWD ? 64'h33 : 64'd0);
        hold = 1'b0;
        #1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("drain%0d_regWrite", k), 64'(regWrite), 64'd1);
            check($sformatf("drain%0d_writeReg", k), 64'(writeReg), 64'(k));
            check($sformatf("drain%0d_writeData", k), 64'(writeData), 64'(17 * k));
            check($sformatf("drain%0d_in_ready", k), 64'(in_ready), (k == 1) ? 64'd0 : 64'd1);
            step();
        end
        check("drain_count", 64'(count), 64'd0);

        // Forwarding priority: youngest match wins, commits oldest first
        hold = 1'b1;
        push(5'd7, 32'hA);
        push(5'd7, 32'hB);
        qReg1 = 5'd7;
        #1;
        check("fwd_qHit1", 64'(qHit1), FWD ? 64'd1 : 64'd0);
        check("fwd_qData1", 64'(qData1), FWD ? 64'hB : 64'd0);
        hold = 1'b0;
        #1;
        check("fwd_commit_a", 64'(writeData), 64'hA);
        step();
        check("fwd_commit_b", 64'(writeData), 64'hB);
        check("fwd_hit_last", 64'(qHit1), FWD ? 64'd1 : 64'd0);
        check("fwd_data_last", 64'(qData1), FWD ? 64'hB : 64'd0);
        step();
        check("fwd_hit_gone", 64'(qHit1), 64'd0);
        check("fwd_count", 64'(count), 64'd0);

        // Register 0 is consumed but not queued
        in_valid = 1'b1; in_reg = 5'd0; in_data = 32'h1234;
        #1;
        check("r0_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        qReg2 = 5'd0;
        #1;
        check("r0_count", 64'(count), 64'd0);
        check("r0_regWrite", 64'(regWrite), 64'd0);
        check("r0_qHit2", 64'(qHit2), 64'd0);

        // Full plus retire: no pass-through
        hold = 1'b1;
        for (int i = 0; i < 4; i++) push(5'(8 + i), 32'(8 + i));
        hold = 1'b0; in_valid = 1'b1; in_reg = 5'd12; in_data = 32'hC;
        #1;
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_count", 64'(count), 64'd4);
        check("full_writeReg", 64'(writeReg), 64'd8);
        step();
        check("full_next_ready", 64'(in_ready), 64'd1);
        check("full_next_count", 64'(count), 64'd3);
        check("full_next_head", 64'(writeReg), 64'd9);
        step();
        in_valid = 1'b0;
        check("full_swap_count", 64'(count), 64'd3);
        for (int k = 10; k <= 12; k++) begin
            check($sformatf("full_drain%0d", k), 64'(writeReg), 64'(k));
            check($sformatf("full_drain%0d_data", k), 64'(writeData), 64'(k));
            step();
        end
        check("full_empty", 64'(count), 64'd0);

        // Reset mid-operation discards pending entries
        hold = 1'b1;
        for (int i = 0; i < 3; i++) push(5'(13 + i), 32'(32'hD0 + i));
        check("mid_count", 64'(count), 64'd3);
        rst_n = 1'b1; qReg1 = 5'd13;
        step();
        rst_n = 1'b0; hold = 1'b0;
        #1;
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_regWrite", 64'(regWrite), 64'd0);
        check("mid_rst_qHit1", 64'(qHit1), 64'd0);
        check("mid_rst_qData1", 64'(qData1), 64'd0);
        check("mid_rst_writeReg", 64'(writeReg), 64'd0);
        check("mid_rst_writeData", 64'(writeData), 64'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("mid_stale%0d", k), 64'(regWrite), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_writeback_queue.md
# reg_writeback_queue

- Ordered write-back buffer in front of the single write port of the 32x32 register bank.
- Accepts register-write requests from the execute/load stages over a valid/ready handshake.
- Queues up to DEPTH entries and retires one per cycle onto the bank's `writeReg`/`writeData`/`regWrite` port.
- Answers two combinational forwarding queries so decode sees pending values not yet committed to the bank.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `ADDR_W`, 5: register index width.
- `DATA_W`, 32: register data width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-high (asserted = 1 resets, despite the name).
- `in_valid`  in  1  write request present.
- `in_ready`  out  1  queue can accept; equals `count < DEPTH`.
- `in_reg`  in  ADDR_W  destination register.
- `in_data`  in  DATA_W  write data.
- `hold`  in  1  when 1, no entry retires this cycle.
- `writeReg`  out  ADDR_W  head entry register index, to the bank.
- `writeData`  out  DATA_W  head entry data, to the bank.
- `regWrite`  out  1  `count != 0 && !hold`.
- `qReg1`, `qReg2`  in  ADDR_W  forwarding query indices.
- `qHit1`, `qHit2`  out  1  a pending entry targets the queried register.
- `qData1`, `qData2`  out  DATA_W  data of the youngest matching pending entry, else 0.
- `count`  out  $clog2(DEPTH)+1  occupancy.

## Operation
- **Storage.** Circular buffer of DEPTH {reg, data} entries with head pointer, tail pointer and count.
  - Pointers wrap modulo DEPTH.
- **Accept.** Fires when `in_valid && in_ready`.
  - Register 0 (`in_reg == 0`): request is consumed (handshake completes) but not enqueued; `count` is unchanged.
  - Any other register: written at tail, tail increments.
- **Retire.** Fires when `regWrite` = 1. The bank commits the head entry at the same edge; head increments.
- **Simultaneous accept and retire.** Both occur; count is unchanged.
  - When full, `in_ready` = 0 even if a retire is happening. There is no pass-through when full.
- **Ordering.** Retirement is strictly FIFO. Multiple pending writes to the same register commit oldest first.
- **Forwarding.** Combinational over stored entries only. The request being accepted this cycle is not visible.
  - Youngest matching entry wins.
  - `qReg` = 0 never hits.
- **Reset.** On a reset edge the queue is flushed: pending entries are discarded, even mid-burst.
  - Post-reset values: `count` = 0, head = tail = 0, all entries = 0.
  - Post-reset outputs: `in_ready` = 1, `regWrite` = 0, `writeReg` = 0, `writeData` = 0, `qHit*` = 0, `qData*` = 0.
- **Empty queue.** `writeReg`/`writeData` show the stale head slot; qualify them with `regWrite`.

## Timing
- Accept at edge N into an empty queue with `hold` = 0:
  - `regWrite` = 1 during cycle N+1.
  - Bank commits at edge N+1.
  - Accept-to-commit latency is 1 cycle.
- Sustained throughput: 1 accept and 1 retire per cycle.
- `hold` high for k cycles delays every retirement by k cycles. Accepts continue until full.
- Forwarding query to commit: `qHit` stays 1 through the cycle of the last matching retire and drops the cycle after it.
- `in_ready`, `regWrite`, `qHit*` and `qData*` are combinational from registered state plus `hold`/`qReg*`. There is no path from `in_valid` to `in_ready`.

## Configuration
- `WBQ_FORWARD_EN` defined: forwarding comparators and muxes are built as described above.
- `WBQ_FORWARD_EN` undefined: no forwarding logic is built. `qHit1`, `qHit2` = 0 and `qData1`, `qData2` = 0 constantly; `qReg*` are ignored. Queue behaviour is otherwise identical.

## Test plan
- **Single write.** Reset, then accept (reg 5, 0xDEADBEEF) with `hold` = 0.
  - Next cycle: `regWrite` = 1, `writeReg` = 5, `writeData` = 0xDEADBEEF.
  - Following cycle: `count` = 0.
- **Fill while held.** `hold` = 1; accept regs 1, 2, 3, 4 with data 0x11, 0x22, 0x33, 0x44.
  - `count` = 4 and `in_ready` = 0.
  - Release `hold`: four consecutive `regWrite` pulses in order 1..4 with matching data; `in_ready` rises after the first retire.
- **Forwarding priority.** `hold` = 1; accept (7, 0xA) then (7, 0xB); query `qReg1` = 7.
  - `qHit1` = 1, `qData1` = 0xB.
  - Release `hold`: commits are 0xA, then 0xB; `qHit1` = 0 after the second retire.
- **Register 0 drop.** Accept (0, 0x1234).
  - Handshake completes; `count` stays 0; no `regWrite`; query `qReg2` = 0 gives `qHit2` = 0.
- **Full plus retire.** Queue full, `hold` = 0, `in_valid` = 1.
  - `in_ready` = 0 this cycle; next cycle `in_ready` = 1; `count` never exceeds 4.
- **Reset mid-operation.** 3 entries pending, assert `rst_n` = 1 for one cycle.
  - Next cycle: `count` = 0, `regWrite` = 0, `qHit*` = 0; no stale entry ever retires.
